led_pattern_ctrl: RTL and testbench
===================================

# led_pattern_ctrl

Key-driven sequencer that produces the 3-bit pattern index `sum` consumed by the LED pattern display block. It debounces three board keys (up, down, mode) and holds the index in one of two modes: MANUAL, where keys step the index, and AUTO, where the index advances on a fixed period. It sits between the raw key pins and the display block's `sum` input in the same `clk` domain.

## Interface
- `DEB_CYCLES`, 1_000_000: cycles a synchronized key level must stay unchanged before it is accepted (20 ms at 50 MHz); minimum 2.
- `STEP_CYCLES`, 25_000_000: AUTO advance period in cycles (0.5 s at 50 MHz); minimum 2.
- `clk` input 1: system clock, 50 MHz.
- `rst_n` input 1: asynchronous, active-low reset.
- `key_up_n` input 1: raw up key, active-low, asynchronous to `clk`.
- `key_down_n` input 1: raw down key, active-low, asynchronous.
- `key_mode_n` input 1: raw mode key, active-low, asynchronous.
- `sum` output 3: pattern index to the display block; registered.
- `auto_on` output 1: high while in AUTO; registered.
- `sum_chg` output 1: one-cycle pulse in the cycle after `sum` changes.

## Operation
- Per key: 2-flop synchronizer -> debouncer -> press pulse.
- Debouncer holds `stable` (reset 1 = released) and a counter (reset 0).
  - Synchronized level equal to `stable`: counter cleared.
  - Level different and counter = DEB_CYCLES-1: `stable` takes the level and the counter clears.
  - Level different otherwise: counter increments.
- Press pulse is high for exactly one cycle, registered with the `stable` 1->0 update. Release produces no pulse.
- FSM states: MANUAL (reset) and AUTO. A mode press toggles the state. `auto_on` = (state == AUTO).
- Up press: `sum` +1 mod 8 (7 -> 0). Down press: `sum` -1 mod 8 (0 -> 7). Up and down pulses in the same cycle: `sum` unchanged, no `sum_chg`.
- AUTO step counter:
  - Cleared on entry to AUTO and on every up/down press while in AUTO.
  - Otherwise counts 0..STEP_CYCLES-1. At terminal count `sum` +1 mod 8 and the counter clears.
  - Held at 0 in MANUAL.
- Priority within one cycle: mode press > up/down press > step tick.
  - Mode press with a step tick: state toggles, no step.
  - Mode press with an up/down press: the state toggles and `sum` also steps.
- Reset at any point, including mid-debounce or mid-period: all state returns to reset values immediately.
- Reset values: `sum`=0, `auto_on`=0, `sum_chg`=0, debouncers released, counters 0.

## Timing
- Key falls before sampling edge E0. Synchronizer output is low after E2. `stable` and the press pulse update at E(2+DEB_CYCLES). `sum` and state update at E(3+DEB_CYCLES). `sum_chg` is high for the cycle after that edge.
- Glitch shorter than DEB_CYCLES cycles at the synchronizer output: no pulse.
- AUTO with no key activity: `sum` changes every STEP_CYCLES cycles exactly. The first step comes STEP_CYCLES cycles after the edge that enters AUTO.
- Holding a key gives a single press pulse, with no auto-repeat.

## Configuration
- `LED_CTRL_AUTO_EN` defined: AUTO mode, step counter and mode-key handling are present as specified.
- `LED_CTRL_AUTO_EN` undefined:
  - Step counter and mode debouncer are removed, and `key_mode_n` is ignored.
  - `auto_on` is tied to 0, the FSM reduces to MANUAL, and STEP_CYCLES is unused.
  - All other behaviour is unchanged.

## Structure
- Package `led_ctrl_pkg` holds:
  - `SUM_W` = 3.
  - `ctrl_state_t` enum {ST_MANUAL, ST_AUTO}.
  - Reset constants `SUM_RST` = 0 and `KEY_IDLE` = 1.
- Sub-module `key_debounce` (params DEB_CYCLES; ports clk, rst_n, key_n, press) contains the synchronizer, the debouncer and the pulse. It is instantiated once per key, and the mode instance exists only under `LED_CTRL_AUTO_EN`.

## Test plan
Bench runs with DEB_CYCLES=4 and STEP_CYCLES=10.
- Hold `key_up_n` low 20 cycles from reset:
  - `sum` goes 0->1 exactly once, at edge E7.
  - `sum_chg` is high for one cycle.
- Pulse `key_up_n` low for 3 cycles: no change to `sum` or `sum_chg`.
- Eight clean up presses wrap `sum` 7->0. One down press from 0 gives `sum`=7.
- Up and down released together, then pressed together and held: `sum` unchanged, no `sum_chg`.
- Mode press then idle 35 cycles:
  - `auto_on`=1.
  - `sum` reaches 3, with steps exactly 10 cycles apart.
  - A second mode press aligned with a terminal count toggles `auto_on` to 0 and does not step.
- Assert `rst_n` mid-debounce and mid-AUTO:
  - `sum`=0 and `auto_on`=0 immediately.
  - A held key gives no spurious pulse until it has been stable for the full DEB_CYCLES after reset release.

Source files
------------

// File: rtl/led_ctrl_pkg.sv
// led_pattern_ctrl shared types and constants.
// Pattern index width, controller states and reset values.
package led_ctrl_pkg;

  localparam int SUM_W = 3;

  typedef enum logic {
    ST_MANUAL = 1'b0,
    ST_AUTO   = 1'b1
  } ctrl_state_t;

  localparam logic [SUM_W-1:0] SUM_RST  = '0;
  localparam logic             KEY_IDLE = 1'b1;

  // inc and dec are never both set by the caller.
  function automatic logic [SUM_W-1:0] sum_next(
    input logic [SUM_W-1:0] s,
    input logic             inc,
    input logic             dec
  );
    logic [SUM_W-1:0] r;
    r = s;
    unique case (1'b1)
      inc:     r = s + SUM_W'(1);
      dec:     r = s - SUM_W'(1);
      default: r = s;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Raw active-low key -> 2-flop sync -> debouncer -> press pulse.
// One pulse per accepted 1->0 transition of the debounced level.
module key_debounce
  import led_ctrl_pkg::*;
#(
  parameter int DEB_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic press
);

  localparam int CNT_W = $clog2(DEB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES - 1);

  logic [1:0]       sync;
  logic             lvl;
  logic             stable;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= {KEY_IDLE, KEY_IDLE};
    end else begin
      sync <= {sync[0], key_n};
    end
  end

  assign lvl = sync[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stable <= KEY_IDLE;
      cnt    <= '0;
      press  <= 1'b0;
    end else begin
      press <= 1'b0;
      if (lvl == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        stable <= lvl;
        cnt    <= '0;
        press  <= ~lvl;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/led_pattern_ctrl.sv
// Key-driven pattern index sequencer, MANUAL and AUTO modes.
// AUTO mode, step timer and mode key exist only with LED_CTRL_AUTO_EN.
module led_pattern_ctrl
  import led_ctrl_pkg::*;
#(
  parameter int DEB_CYCLES  = 1_000_000,
  parameter int STEP_CYCLES = 25_000_000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             key_up_n,
  input  logic             key_down_n,
  input  logic             key_mode_n,
  output logic [SUM_W-1:0] sum,
  output logic             auto_on,
  output logic             sum_chg
);

  logic             up_press;
  logic             down_press;
  logic             step_tick;
  logic             inc;
  logic             dec;
  logic [SUM_W-1:0] sum_nxt;

  key_debounce #(
    .DEB_CYCLES(DEB_CYCLES)
  ) u_up (
    .clk  (clk),
    .rst_n(rst_n),
    .key_n(key_up_n),
    .press(up_press)
  );

  key_debounce #(
    .DEB_CYCLES(DEB_CYCLES)
  ) u_down (
    .clk  (clk),
    .rst_n(rst_n),
    .key_n(key_down_n),
    .press(down_press)
  );

`ifdef LED_CTRL_AUTO_EN
  localparam int STEP_W = $clog2(STEP_CYCLES);
  localparam logic [STEP_W-1:0] STEP_MAX =
    STEP_W'(STEP_CYCLES - 1);

  logic              mode_press;
  ctrl_state_t       state;
  ctrl_state_t       state_nxt;
  logic [STEP_W-1:0] step_cnt;
  logic [STEP_W-1:0] step_cnt_nxt;

  key_debounce #(
    .DEB_CYCLES(DEB_CYCLES)
  ) u_mode (
    .clk  (clk),
    .rst_n(rst_n),
    .key_n(key_mode_n),
    .press(mode_press)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_MANUAL;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (mode_press) begin
      unique case (state)
        ST_MANUAL: state_nxt = ST_AUTO;
        ST_AUTO:   state_nxt = ST_MANUAL;
        default:   state_nxt = ST_MANUAL;
      endcase
    end
  end

  always_comb begin
    auto_on = (state == ST_AUTO);
  end

  // Mode press and key presses both pre-empt a coincident tick.
  assign step_tick = (state == ST_AUTO) &&
                     !mode_press &&
                     !up_press && !down_press &&
                     (step_cnt == STEP_MAX);

  always_comb begin
    step_cnt_nxt = step_cnt + 1'b1;
    if (mode_press || state == ST_MANUAL) begin
      step_cnt_nxt = '0;
    end else if (up_press || down_press || step_tick) begin
      step_cnt_nxt = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_cnt <= '0;
    end else begin
      step_cnt <= step_cnt_nxt;
    end
  end
`else
  logic unused_mode;
  localparam int unused_step = STEP_CYCLES;

  assign unused_mode = key_mode_n;
  assign step_tick   = 1'b0;
  assign auto_on     = 1'b0;
`endif

  // Up and down together cancel out.
  assign inc = (up_press & ~down_press) | step_tick;
  assign dec = down_press & ~up_press;

  always_comb begin
    sum_nxt = sum_next(sum, inc, dec);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum     <= SUM_RST;
      sum_chg <= 1'b0;
    end else begin
      sum     <= sum_nxt;
      sum_chg <= (sum_nxt != sum);
    end
  end

endmodule

// File: tb/tb_led_pattern_ctrl.sv
// Self-checking bench for led_pattern_ctrl.
// Builds with or without LED_CTRL_AUTO_EN.
module tb_led_pattern_ctrl;

  localparam int DEB  = 4;
  localparam int STEP = 10;
`ifdef LED_CTRL_AUTO_EN
  localparam bit AUTO_EN = 1'b1;
`else
  localparam bit AUTO_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       key_up_n = 1'b1;
  logic       key_down_n = 1'b1;
  logic       key_mode_n = 1'b1;
  logic [2:0] sum;
  logic       auto_on;
  logic       sum_chg;

  int errors = 0;
  int checks = 0;

  led_pattern_ctrl #(
    .DEB_CYCLES (DEB),
    .STEP_CYCLES(STEP)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_up_n  (key_up_n),
    .key_down_n(key_down_n),
    .key_mode_n(key_mode_n),
    .sum       (sum),
    .auto_on   (auto_on),
    .sum_chg   (sum_chg)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d",
               nm, act, exp);
    end
  endtask

  // Model: a key level is accepted once the last DEB
  // synchronized samples (raw samples delayed two edges)
  // all disagree with the accepted level.
  bit [31:0] hist [3];
  bit        mst  [3];
  bit        mp   [3];
  bit        raw  [3];
  int        m_sum = 0;
  bit        m_auto = 0;
  bit        m_chg = 0;
  int        m_since = 0;
  int        ns;
  bit        up, dn, md, tk, all;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 3; k++) begin
        hist[k] = '1;
        mst[k]  = 1'b1;
        mp[k]   = 1'b0;
      end
      m_sum   = 0;
      m_auto  = 0;
      m_chg   = 0;
      m_since = 0;
    end else begin
      up = mp[0];
      dn = mp[1];
      md = AUTO_EN && mp[2];
      ns = m_sum;
      if (up && !dn) ns = (m_sum + 1) % 8;
      if (dn && !up) ns = (m_sum + 7) % 8;
      tk = m_auto && !md && !up && !dn &&
           (m_since + 1 == STEP);
      if (tk) ns = (m_sum + 1) % 8;
      if (md) begin
        m_auto  = !m_auto;
        m_since = 0;
      end else if (m_auto) begin
        m_since = (up || dn || tk) ? 0 : m_since + 1;
      end
      m_chg = (ns != m_sum);
      m_sum = ns;
      raw[0] = key_up_n;
      raw[1] = key_down_n;
      raw[2] = key_mode_n;
      for (int k = 0; k < 3; k++) begin
        all = 1'b1;
        for (int j = 1; j <= DEB; j++)
          if (hist[k][j] == mst[k]) all = 1'b0;
        mp[k] = 1'b0;
        if (all) begin
          mst[k] = ~mst[k];
          mp[k]  = (mst[k] == 1'b0);
        end
        hist[k] = {hist[k][30:0], raw[k]};
      end
    end
  end

  always @(negedge clk) begin
    chk("model_sum", 32'(sum), 32'(m_sum));
    chk("model_auto_on", 32'(auto_on), 32'(m_auto));
    chk("model_sum_chg", 32'(sum_chg), 32'(m_chg));
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
  endtask

  task automatic press(input int which);
    if (which == 0) key_up_n = 1'b0;
    else key_down_n = 1'b0;
    tick(10);
    key_up_n   = 1'b1;
    key_down_n = 1'b1;
    tick(10);
  endtask

  int npulse;
  int tq[$];

  initial begin
    do_reset();
    chk("rst_sum", 32'(sum), 0);
    chk("rst_auto_on", 32'(auto_on), 0);
    chk("rst_sum_chg", 32'(sum_chg), 0);

    // held up key: single step at E7
    key_up_n = 1'b0;
    tick(6);
    chk("hold_e6_sum", 32'(sum), 0);
    tick(1);
    chk("hold_e7_sum", 32'(sum), 1);
    chk("hold_e7_chg", 32'(sum_chg), 1);
    npulse = 0;
    for (int i = 0; i < 12; i++) begin
      tick(1);
      if (sum_chg) npulse++;
    end
    chk("hold_no_repeat", 32'(npulse), 0);
    chk("hold_sum", 32'(sum), 1);
    key_up_n = 1'b1;
    tick(10);

    // 3-cycle glitch
    key_up_n = 1'b0;
    tick(3);
    key_up_n = 1'b1;
    npulse = 0;
    for (int i = 0; i < 12; i++) begin
      tick(1);
      if (sum_chg) npulse++;
    end
    chk("glitch_pulses", 32'(npulse), 0);
    chk("glitch_sum", 32'(sum), 1);

    // wrap up and down
    do_reset();
    for (int i = 1; i <= 8; i++) begin
      press(0);
      if (i == 3) chk("up3_sum", 32'(sum), 3);
      if (i == 7) chk("up7_sum", 32'(sum), 7);
    end
    chk("wrap_up_sum", 32'(sum), 0);
    press(1);
    chk("wrap_down_sum", 32'(sum), 7);

    // up and down together
    key_up_n   = 1'b0;
    key_down_n = 1'b0;
    npulse = 0;
    for (int i = 0; i < 15; i++) begin
      tick(1);
      if (sum_chg) npulse++;
    end
    chk("both_pulses", 32'(npulse), 0);
    chk("both_sum", 32'(sum), 7);
    key_up_n   = 1'b1;
    key_down_n = 1'b1;
    tick(10);

    // AUTO stepping, second mode press on a terminal count
    do_reset();
    key_mode_n = 1'b0;
    tq.delete();
    for (int k = 1; k <= 60; k++) begin
      tick(1);
      if (k == 10) key_mode_n = 1'b1;
      if (k == 40) key_mode_n = 1'b0;
      if (k == 48) key_mode_n = 1'b1;
      if (sum_chg) tq.push_back(k);
`ifdef LED_CTRL_AUTO_EN
      if (k == 6) chk("auto_e6", 32'(auto_on), 0);
      if (k == 7) chk("auto_e7", 32'(auto_on), 1);
      if (k == 46) chk("auto_e46", 32'(auto_on), 1);
      if (k == 47) chk("auto_e47", 32'(auto_on), 0);
`endif
    end
`ifdef LED_CTRL_AUTO_EN
    chk("auto_nsteps", 32'(tq.size()), 3);
    for (int i = 0; i < 3; i++)
      chk("auto_step_at",
          (i < tq.size()) ? 32'(tq[i]) : 32'hffff_ffff,
          32'(17 + i * STEP));
    chk("auto_sum", 32'(sum), 3);
`else
    chk("noauto_nsteps", 32'(tq.size()), 0);
    chk("noauto_sum", 32'(sum), 0);
`endif
    chk("auto_off", 32'(auto_on), 0);

    // reset mid-AUTO and mid-debounce
    do_reset();
    key_mode_n = 1'b0;
    for (int k = 1; k <= 23; k++) begin
      tick(1);
      if (k == 10) key_mode_n = 1'b1;
      if (k == 20) key_up_n = 1'b0;
    end
`ifdef LED_CTRL_AUTO_EN
    chk("pre_rst_sum", 32'(sum), 1);
    chk("pre_rst_auto", 32'(auto_on), 1);
`endif
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_sum", 32'(sum), 0);
    chk("async_rst_auto", 32'(auto_on), 0);
    tick(2);
    rst_n = 1'b1;
    tick(6);
    chk("post_rst_e6_sum", 32'(sum), 0);
    tick(1);
    chk("post_rst_e7_sum", 32'(sum), 1);
    chk("post_rst_e7_chg", 32'(sum_chg), 1);
    key_up_n = 1'b1;
    tick(10);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
